// File: rtl/data_cache_nway_if.sv
// Load/store-side bus of the N-way write-back data cache.
// Carries lookup, store, refill, AXI address and fence handshake signals.
interface data_cache_nway_if #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WIDTH = 256,
  parameter int ADDR_WIDTH  = 32
);
  logic                   write_en;
  logic                   block_write_en;
  logic                   lru_update;
  logic [ADDR_WIDTH-1:0]  i_addr;
  logic [WORD_SIZE-1:0]   i_data;
  logic [BLOCK_WIDTH-1:0] i_data_block;
  logic [1:0]             i_store_type;
  logic                   i_addr_control;
  logic                   i_start_fence;
  logic                   i_wb_done;
  logic [WORD_SIZE-1:0]   o_data;
  logic [BLOCK_WIDTH-1:0] o_data_block;
  logic                   o_hit;
  logic                   o_dirty;
  logic [ADDR_WIDTH-1:0]  o_addr_axi;
  logic                   o_wb_req;
  logic                   o_busy;
  logic                   o_fence_done;
  logic                   o_store_addr_ma;

  modport master (
    output write_en, block_write_en, lru_update,
    output i_addr, i_data, i_data_block, i_store_type,
    output i_addr_control, i_start_fence, i_wb_done,
    input  o_data, o_data_block, o_hit, o_dirty,
    input  o_addr_axi, o_wb_req, o_busy, o_fence_done,
    input  o_store_addr_ma
  );

  modport slave (
    input  write_en, block_write_en, lru_update,
    input  i_addr, i_data, i_data_block, i_store_type,
    input  i_addr_control, i_start_fence, i_wb_done,
    output o_data, o_data_block, o_hit, o_dirty,
    output o_addr_axi, o_wb_req, o_busy, o_fence_done,
    output o_store_addr_ma
  );
endinterface

// File: rtl/data_cache_nway.sv
// N-way set-associative write-back data cache with true-LRU ages
// and a fence walker that writes back every dirty line.
module data_cache_nway #(
  parameter int SET_COUNT   = 4,
  parameter int WAYS        = 4,
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WIDTH = 256,
  parameter int ADDR_WIDTH  = 32
) (
  input logic              clk,
  input logic              arst,
  data_cache_nway_if.slave bus
);
  localparam int BO = $clog2(WORD_SIZE/8);
  localparam int WO = $clog2(BLOCK_WIDTH/WORD_SIZE);
  localparam int IW = $clog2(SET_COUNT);
  localparam int WW = $clog2(WAYS);
  localparam int TW = ADDR_WIDTH-IW-WO-BO;
  localparam int NB = WORD_SIZE/8;
  localparam int LW = IW+WW;
  localparam int BW = $clog2(BLOCK_WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_e;

  logic [TW-1:0]          tag_q   [SET_COUNT][WAYS];
  logic [BLOCK_WIDTH-1:0] data_q  [SET_COUNT][WAYS];
  logic [WW-1:0]          age_q   [SET_COUNT][WAYS];
  logic [WAYS-1:0]        valid_q [SET_COUNT];
  logic [WAYS-1:0]        dirty_q [SET_COUNT];

  state_e        state_q, state_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic          wb_clr;

  logic [BO-1:0] boff;
  logic [WO-1:0] woff;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [BW-1:0] wbit;
  logic [IW-1:0] fset;
  logic [WW-1:0] fway;

  assign boff = bus.i_addr[BO-1:0];
  assign woff = bus.i_addr[BO +: WO];
  assign idx  = bus.i_addr[BO+WO +: IW];
  assign tag  = bus.i_addr[ADDR_WIDTH-1 -: TW];
  assign wbit = {woff, {(BW-WO){1'b0}}};
  assign fset = ptr_q[LW-1:WW];
  assign fway = ptr_q[WW-1:0];

  logic          hit, inv;
  logic [WW-1:0] hit_way, inv_way, old_way, vic_way, sel_way;

  // Descending scan so the lowest matching/invalid way wins.
  always_comb begin
    hit     = 1'b0;
    inv     = 1'b0;
    hit_way = '0;
    inv_way = '0;
    old_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv     = 1'b1;
        inv_way = WW'(w);
      end
      if (age_q[idx][w] == WW'(WAYS-1))
        old_way = WW'(w);
    end
    vic_way = inv ? inv_way : old_way;
    sel_way = hit ? hit_way : vic_way;
  end

  logic [NB-1:0]        bmask;
  logic [WORD_SIZE-1:0] wdata, cur_word, new_word;
  logic                 ma;

  always_comb begin
    bmask = '0;
    wdata = bus.i_data;
    ma    = 1'b1;
    case (bus.i_store_type)
      2'b00: begin
        bmask = NB'(1) << boff;
        wdata = {NB{bus.i_data[7:0]}};
        ma    = 1'b0;
      end
      2'b01: begin
        bmask = NB'(3) << {boff[BO-1:1], 1'b0};
        wdata = {(NB/2){bus.i_data[15:0]}};
        ma    = boff[0];
      end
      2'b10: begin
        bmask = '1;
        ma    = |boff;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_word = data_q[idx][hit_way][wbit +: WORD_SIZE];
    new_word = cur_word;
    for (int b = 0; b < NB; b++)
      if (bmask[b]) new_word[b*8 +: 8] = wdata[b*8 +: 8];
  end

  logic busy, do_store, do_fill, do_lru;

  assign busy     = state_q != IDLE;
  assign do_store = !busy && bus.write_en && hit
                    && bus.i_store_type != 2'b11;
  assign do_fill  = !busy && !bus.write_en && bus.block_write_en;
  assign do_lru   = !busy && bus.lru_update;

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= WW'(w);
        end
      end
    end else begin
      if (do_store) begin
        data_q[idx][hit_way][wbit +: WORD_SIZE] <= new_word;
        dirty_q[idx][hit_way] <= 1'b1;
      end else if (do_fill) begin
        data_q[idx][vic_way]  <= bus.i_data_block;
        tag_q[idx][vic_way]   <= tag;
        valid_q[idx][vic_way] <= 1'b1;
        dirty_q[idx][vic_way] <= 1'b0;
      end
      if (do_lru) begin
        for (int w = 0; w < WAYS; w++)
          if (age_q[idx][w] < age_q[idx][sel_way])
            age_q[idx][w] <= age_q[idx][w] + WW'(1);
        age_q[idx][sel_way] <= '0;
      end
      if (wb_clr) dirty_q[fset][fway] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wb_clr  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.i_start_fence) begin
        state_d = SCAN;
        ptr_d   = '0;
      end
      SCAN: begin
        if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
          state_d = WB;
        end else begin
          ptr_d = ptr_q + LW'(1);
          if (&ptr_q) state_d = DONE;
        end
      end
      WB: if (bus.i_wb_done) begin
        wb_clr  = 1'b1;
        ptr_d   = ptr_q + LW'(1);
        state_d = (&ptr_q) ? DONE : SCAN;
      end
      DONE: state_d = IDLE;
    endcase
  end

  localparam logic [WO+BO-1:0] LZ = '0;

  assign bus.o_hit           = hit;
  assign bus.o_data          = data_q[idx][sel_way][wbit +: WORD_SIZE];
  assign bus.o_store_addr_ma = ma;
  assign bus.o_wb_req        = state_q == WB;
  assign bus.o_busy          = busy;
  assign bus.o_fence_done    = state_q == DONE;
  assign bus.o_dirty         = busy ? dirty_q[fset][fway]
                                    : dirty_q[idx][sel_way];
  assign bus.o_data_block    = busy ? data_q[fset][fway]
                                    : data_q[idx][vic_way];
  assign bus.o_addr_axi =
    busy               ? {tag_q[fset][fway], fset, LZ} :
    bus.i_addr_control ? {tag, idx, LZ} :
                         {tag_q[idx][vic_way], idx, LZ};
endmodule

// File: tb/tb_data_cache_nway.sv
// Directed bench for data_cache_nway: vector table for lookups/stores/LRU,
// hand sequences for fence write-back, hold, latency and reset abort.
module tb_data_cache_nway;
  logic clk;
  logic arst;
  int   checks;
  int   errors;

  data_cache_nway_if #(
    .WORD_SIZE(32), .BLOCK_WIDTH(256), .ADDR_WIDTH(32)
  ) bus ();

  data_cache_nway #(
    .SET_COUNT(4), .WAYS(4), .WORD_SIZE(32),
    .BLOCK_WIDTH(256), .ADDR_WIDTH(32)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we, bwe, lru, ac;
    logic [1:0]  st;
    logic [31:0] addr, data, base;
    logic        hit, dirty, ma;
    logic [31:0] rdata, axi;
  } vec_t;

  function automatic vec_t mkv(
    input logic we, bwe, lru, ac,
    input logic [1:0] st,
    input logic [31:0] addr, data, base,
    input logic hit, dirty, ma,
    input logic [31:0] rdata, axi
  );
    vec_t v;
    v.we = we; v.bwe = bwe; v.lru = lru; v.ac = ac;
    v.st = st; v.addr = addr; v.data = data; v.base = base;
    v.hit = hit; v.dirty = dirty; v.ma = ma;
    v.rdata = rdata; v.axi = axi;
    return v;
  endfunction

  function automatic logic [255:0] mkblk(input logic [31:0] base);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = base + 32'(j);
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.write_en       = 1'b0;
    bus.block_write_en = 1'b0;
    bus.lru_update     = 1'b0;
    bus.i_start_fence  = 1'b0;
    bus.i_wb_done      = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string lbl);
    bus.write_en       = v.we;
    bus.block_write_en = v.bwe;
    bus.lru_update     = v.lru;
    bus.i_addr_control = v.ac;
    bus.i_store_type   = v.st;
    bus.i_addr         = v.addr;
    bus.i_data         = v.data;
    bus.i_data_block   = mkblk(v.base);
    #1;
    chk({lbl, " hit"},   256'(bus.o_hit),   256'(v.hit));
    chk({lbl, " dirty"}, 256'(bus.o_dirty), 256'(v.dirty));
    chk({lbl, " ma"},    256'(bus.o_store_addr_ma), 256'(v.ma));
    chk({lbl, " data"},  256'(bus.o_data),  256'(v.rdata));
    chk({lbl, " axi"},   256'(bus.o_addr_axi), 256'(v.axi));
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  vec_t tbl [35];
  vec_t ftb [7];
  int   n, dn, first;
  logic [255:0] eb;

  initial begin
    checks = 0;
    errors = 0;
    bus.i_addr = '0;
    bus.i_data = '0;
    bus.i_data_block = '0;
    bus.i_store_type = 2'b00;
    bus.i_addr_control = 1'b1;

    //           we bwe lru ac st  addr  data  base  hit d ma rdata axi
    tbl[0]  = mkv(0,1,0,1,0,'h080,0,'h11110000,0,0,0,0,'h080);
    tbl[1]  = mkv(0,0,0,1,0,'h084,0,0,1,0,0,'h11110001,'h080);
    tbl[2]  = mkv(0,1,0,0,0,'h100,0,'h22220000,0,0,0,0,0);
    tbl[3]  = mkv(0,1,0,0,0,'h180,0,'h33330000,0,0,0,0,0);
    tbl[4]  = mkv(0,1,0,0,0,'h200,0,'h44440000,0,0,0,0,0);
    tbl[5]  = mkv(0,0,0,1,0,'h18C,0,0,1,0,0,'h33330003,'h180);
    tbl[6]  = mkv(0,0,0,0,0,'h280,0,0,0,0,0,'h44440000,'h200);
    tbl[7]  = mkv(0,1,0,1,0,'h0A0,0,'h51510000,0,0,0,0,'h0A0);
    tbl[8]  = mkv(0,1,0,1,0,'h120,0,'h52520000,0,0,0,0,'h120);
    tbl[9]  = mkv(0,1,0,1,0,'h1A0,0,'h53530000,0,0,0,0,'h1A0);
    tbl[10] = mkv(0,1,0,1,0,'h220,0,'h54540000,0,0,0,0,'h220);
    tbl[11] = mkv(0,0,1,1,0,'h0A0,0,0,1,0,0,'h51510000,'h0A0);
    tbl[12] = mkv(0,0,1,1,0,'h1A0,0,0,1,0,0,'h53530000,'h1A0);
    tbl[13] = mkv(0,0,1,1,0,'h220,0,0,1,0,0,'h54540000,'h220);
    tbl[14] = mkv(0,0,0,0,0,'h320,0,0,0,0,0,'h52520000,'h120);
    tbl[15] = mkv(0,1,0,0,0,'h320,0,'h56560000,0,0,0,'h52520000,'h120);
    tbl[16] = mkv(0,0,1,1,0,'h320,0,0,1,0,0,'h56560000,'h320);
    tbl[17] = mkv(0,0,0,0,0,'h3A0,0,0,0,0,0,'h51510000,'h0A0);
    tbl[18] = mkv(0,0,1,1,0,'h0A0,0,0,1,0,0,'h51510000,'h0A0);
    tbl[19] = mkv(0,0,0,0,0,'h3A0,0,0,0,0,0,'h53530000,'h1A0);
    tbl[20] = mkv(1,0,0,1,2,'h088,'hDEADBEEF,0,1,0,0,'h11110002,'h080);
    tbl[21] = mkv(1,0,0,1,0,'h089,'h55,0,1,1,0,'hDEADBEEF,'h080);
    tbl[22] = mkv(0,0,0,1,0,'h089,0,0,1,1,0,'hDEAD55EF,'h080);
    tbl[23] = mkv(1,0,0,1,1,'h08A,'h1234CAFE,0,1,1,0,'hDEAD55EF,'h080);
    tbl[24] = mkv(0,0,0,1,0,'h088,0,0,1,1,0,'hCAFE55EF,'h080);
    tbl[25] = mkv(0,0,0,1,1,'h081,0,0,1,1,1,'h11110000,'h080);
    tbl[26] = mkv(0,0,0,1,2,'h082,0,0,1,1,1,'h11110000,'h080);
    tbl[27] = mkv(0,0,0,1,0,'h083,0,0,1,1,0,'h11110000,'h080);
    tbl[28] = mkv(1,0,0,1,3,'h100,'hFFFFFFFF,0,1,0,1,'h22220000,'h100);
    tbl[29] = mkv(0,0,0,1,0,'h100,0,0,1,0,0,'h22220000,'h100);
    tbl[30] = mkv(1,0,0,1,2,'h480,'hFFFFFFFF,0,0,0,0,'h44440000,'h480);
    tbl[31] = mkv(0,0,0,0,0,'h480,0,0,0,0,0,'h44440000,'h200);
    tbl[32] = mkv(1,1,0,1,2,'h08C,'h0BADF00D,'h99990000,1,1,0,'h11110003,'h080);
    tbl[33] = mkv(0,0,0,1,0,'h08C,0,0,1,1,0,'h0BADF00D,'h080);
    tbl[34] = mkv(0,0,0,0,0,'h280,0,0,0,0,0,'h44440000,'h200);

    ftb[0] = mkv(0,1,0,1,0,'h080,0,'h11110000,0,0,0,0,'h080);
    ftb[1] = mkv(0,1,0,1,0,'h100,0,'h12120000,0,0,0,0,'h100);
    ftb[2] = mkv(0,1,0,1,0,'h180,0,'h13130000,0,0,0,0,'h180);
    ftb[3] = mkv(0,1,0,1,0,'h0E0,0,'h31310000,0,0,0,0,'h0E0);
    ftb[4] = mkv(0,1,0,1,0,'h160,0,'h32320000,0,0,0,0,'h160);
    ftb[5] = mkv(1,0,0,1,2,'h184,'hA5A5A5A5,0,1,0,0,'h13130001,'h180);
    ftb[6] = mkv(1,0,0,1,2,'h16C,'h5A5A5A5A,0,1,0,0,'h32320003,'h160);

    do_reset();
    bus.i_addr = 32'h0000_0484;
    #1;
    chk("rst hit",   256'(bus.o_hit), 0);
    chk("rst dirty", 256'(bus.o_dirty), 0);
    chk("rst busy",  256'(bus.o_busy), 0);
    chk("rst wbreq", 256'(bus.o_wb_req), 0);
    chk("rst done",  256'(bus.o_fence_done), 0);
    chk("rst data",  256'(bus.o_data), 0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    do_reset();
    foreach (ftb[i]) apply(ftb[i], $sformatf("f%0d", i));

    // Fence over two dirty lines: set0/way2 then set3/way1.
    bus.i_start_fence = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      bus.i_start_fence = 1'b0;
      n++;
    end while (!bus.o_wb_req && n < 100);
    chk("wb1 latency", 256'(n), 4);
    chk("wb1 addr", 256'(bus.o_addr_axi), 'h180);
    eb = mkblk(32'h13130000);
    eb[63:32] = 32'hA5A5A5A5;
    chk("wb1 block", bus.o_data_block, eb);
    chk("wb1 busy", 256'(bus.o_busy), 1);
    chk("wb1 dirty", 256'(bus.o_dirty), 1);
    bus.i_addr = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wb1 hold%0d", k), 256'(bus.o_wb_req), 1);
    end
    chk("wb1 hold addr", 256'(bus.o_addr_axi), 'h180);
    bus.i_wb_done = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      bus.i_wb_done = 1'b0;
      n++;
    end while (!bus.o_wb_req && n < 100);
    chk("wb2 latency", 256'(n), 12);
    chk("wb2 addr", 256'(bus.o_addr_axi), 'h160);
    eb = mkblk(32'h32320000);
    eb[127:96] = 32'h5A5A5A5A;
    chk("wb2 block", bus.o_data_block, eb);
    bus.i_wb_done = 1'b1;
    n = 0; dn = 0; first = 0;
    repeat (6) begin
      @(posedge clk); #1;
      bus.i_wb_done = 1'b0;
      n++;
      if (bus.o_fence_done) begin
        dn++;
        if (first == 0) first = n;
      end
    end
    chk("fence1 done at", 256'(first), 3);
    chk("fence1 done count", 256'(dn), 1);
    chk("fence1 idle", 256'(bus.o_busy), 0);
    apply(mkv(0,0,0,1,0,'h184,0,0,1,0,0,'hA5A5A5A5,'h180), "post1a");
    apply(mkv(0,0,0,1,0,'h16C,0,0,1,0,0,'h5A5A5A5A,'h160), "post1b");

    // Clean fence: full-walk latency; stores and restarts ignored.
    bus.i_start_fence = 1'b1;
    n = 0; dn = 0; first = 0;
    repeat (24) begin
      @(posedge clk); #1;
      bus.i_start_fence = (n == 4);
      n++;
      bus.write_en     = (n == 1);
      bus.i_store_type = 2'b10;
      bus.i_addr       = 32'h184;
      bus.i_data       = 32'hFFFFFFFF;
      if (bus.o_fence_done) begin
        dn++;
        if (first == 0) first = n;
      end
    end
    idle_inputs();
    chk("fence2 done at", 256'(first), 17);
    chk("fence2 done count", 256'(dn), 1);
    apply(mkv(0,0,0,1,0,'h184,0,0,1,0,0,'hA5A5A5A5,'h180), "post2");

    // Reset in WB aborts the fence without a done pulse.
    apply(mkv(1,0,0,1,2,'h080,'hC0FFEE00,0,1,0,0,'h11110000,'h080), "ab0");
    bus.i_start_fence = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      bus.i_start_fence = 1'b0;
      n++;
    end while (!bus.o_wb_req && n < 100);
    chk("ab wb latency", 256'(n), 2);
    arst = 1'b1;
    @(posedge clk); #1;
    chk("ab wbreq", 256'(bus.o_wb_req), 0);
    chk("ab busy", 256'(bus.o_busy), 0);
    arst = 1'b0;
    dn = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.o_fence_done) dn++;
    end
    chk("ab no done", 256'(dn), 0);
    apply(mkv(0,1,0,1,0,'h080,0,'h77770000,0,0,0,0,'h080), "ab1");
    apply(mkv(1,0,0,1,2,'h080,'h12345678,0,1,0,0,'h77770000,'h080), "ab2");
    bus.i_start_fence = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      bus.i_start_fence = 1'b0;
      n++;
    end while (!bus.o_wb_req && n < 100);
    chk("ab3 latency", 256'(n), 2);
    chk("ab3 addr", 256'(bus.o_addr_axi), 'h080);
    eb = mkblk(32'h77770000);
    eb[31:0] = 32'h12345678;
    chk("ab3 block", bus.o_data_block, eb);
    bus.i_wb_done = 1'b1;
    n = 0; dn = 0; first = 0;
    repeat (24) begin
      @(posedge clk); #1;
      bus.i_wb_done = 1'b0;
      n++;
      if (bus.o_fence_done) begin
        dn++;
        if (first == 0) first = n;
      end
    end
    chk("ab3 done at", 256'(first), 16);
    chk("ab3 done count", 256'(dn), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
